shared_timer_arbiter: RTL and testbench
=======================================

// Module: shared_timer_arbiter
// PURPOSE
//  Shares a single countdown timer (the programmable cycle counter behind our slow-tick generation)
//  among NUM_REQ requesters using round-robin arbitration. A granted requester owns the timer for
//  exactly its requested number of clk cycles, then receives a one-cycle done pulse.
//  Sits between control FSMs that need delays/ticks and the one counter resource they share.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  CNT_W    32  width of each requested count and of the shared counter
// PORTS
//  clk        in   1              system clock; all logic on posedge
//  reset      in   1              synchronous, active-high reset
//  req        in   NUM_REQ        req[i]=1 requests the timer; must stay high until done[i]
//  req_count  in   NUM_REQ*CNT_W  req_count[i*CNT_W +: CNT_W] = cycles requested by requester i
//  grant      out  NUM_REQ        one-hot (or zero); grant[i]=1 while i owns the timer
//  done       out  NUM_REQ        one-cycle pulse to owner when its count expires
//  busy       out  1              1 while any grant is asserted (== |grant)
//  active_id  out  $clog2(NUM_REQ) index of current/last owner
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, grant=0, done=0, busy=0, active_id=0, counter=0,
//   rr pointer last=NUM_REQ-1 (requester 0 has top priority first). Reset mid-RUN aborts, no done.
//  All outputs registered. States: IDLE, RUN.
//  IDLE, cycle t, any req high: winner = first i with req[i]=1 searching last+1, last+2, ... mod NUM_REQ.
//   Edge end of t: grant[winner]<=1, busy<=1, active_id<=winner, last<=winner,
//   counter<=req_count[winner] (0 treated as 1), state<=RUN. Count sampled only here.
//  RUN: counter decrements by 1 each cycle; no wrap (never decrements below 1 in RUN).
//   Completion: RUN with counter==1 and req[owner]==1 -> next edge: done[owner]<=1, grant<=0,
//   busy<=0, state<=IDLE. Grant therefore high for exactly max(count,1) cycles (t+1..t+count);
//   done high in cycle t+count+1 only.
//  Abort: RUN with req[owner]==0 -> next edge grant<=0, busy<=0, state<=IDLE, no done.
//   Abort wins over completion in the same cycle.
//  The IDLE cycle carrying done also arbitrates; earliest next grant is t+count+2 (1-cycle gap).
//  Requests from non-owners during RUN are ignored until IDLE; req_count changes during RUN ignored.
//  Fairness: requester just served has lowest priority on next arbitration.
//  done is never asserted while grant is asserted; at most one done bit set per cycle.
//  active_id holds its value in IDLE.
// TESTING
//  1. reset, req=4'b0001, count0=5 -> grant=0001 cycles 1..5 after req, done[0] cycle 6 only, busy mirrors grant.
//  2. req=4'b1111 held, all counts=2 -> grants in order 0,1,2,3,0 each 2 cycles, 1-cycle gap, done each.
//  3. count1=0, req[1] only -> grant[1] exactly 1 cycle, then done[1] pulse.
//  4. req[2] count=10, drop req[2] after 3 grant cycles -> grant drops next edge, done stays 0, next req served.
//  5. reset asserted mid-RUN (count=8, cycle 4) -> next edge all outputs 0, no done; rr restarts at 0.
//  6. req[3] held, count3 changed during RUN 4->100 -> still completes after 4 cycles (count latched at grant).

Source files
------------

// File: rtl/shared_timer_arbiter.sv
// rtl/shared_timer_arbiter.sv - round-robin arbiter sharing one countdown timer among requesters
//
// Purpose:
//   Several control FSMs share a single programmable cycle counter. In IDLE, a
//   round-robin search starting just after the last owner picks the next
//   requester. That requester owns the counter for max(count,1) cycles and then
//   gets a one-cycle done pulse. If the owner drops req early, the run ends
//   with no done.
//
// Ports:
//   clk        system clock, posedge
//   reset      synchronous active-high reset
//   req        per-requester request; held high until done
//   req_count  per-requester cycle count, packed CNT_W slices
//   grant      one-hot (or zero) ownership
//   done       one-cycle completion pulse to the owner
//   busy       |grant
//   active_id  index of current/last owner
module shared_timer_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 32,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [ID_W-1:0]          active_id
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      active_id_q, active_id_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [ID_W-1:0]      winner;
  logic                 found;
  logic [CNT_W-1:0]     cnt_sel;

  // The search covers last+1 .. last+NUM_REQ (mod NUM_REQ). This visits the
  // previous owner last, so it gets the lowest priority.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) cnt_sel = req_count[i*CNT_W +: CNT_W];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      active_id_q <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      active_id_q <= active_id_d;
      last_q      <= last_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (found) state_d = RUN;
      RUN:  if (!req[active_id_q] || count_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. Every output is taken from a register.
  always_comb begin
    grant_d     = grant_q;
    done_d      = '0;
    active_id_d = active_id_q;
    last_d      = last_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (found) begin
          grant_d     = NUM_REQ'(1) << winner;
          active_id_d = winner;
          last_d      = winner;
          // A zero count still gives one cycle of ownership.
          count_d     = (cnt_sel == '0) ? CNT_W'(1) : cnt_sel;
        end
      end
      RUN: begin
        // If the owner drops req, that takes priority over completion.
        if (!req[active_id_q]) begin
          grant_d = '0;
        end else if (count_q == CNT_W'(1)) begin
          grant_d              = '0;
          done_d[active_id_q]  = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: grant_d = '0;
    endcase
    busy_d = |grant_d;
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// tb/tb_shared_timer_arbiter.sv - directed self-checking bench for shared_timer_arbiter
module tb_shared_timer_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_count;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [1:0]     active_id;

  int checks = 0;
  int errors = 0;

  shared_timer_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_count (req_count),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .active_id (active_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input int i, input logic [W-1:0] v);
    req_count[i*W +: W] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    req_count = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 4'b1111;
    req_count = '0;
    step();
    step();
    checks++;
    if ({grant, done, busy, active_id} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got g=%b d=%b b=%b id=%0d exp all 0", grant, done, busy, active_id);
    end
    req = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] eg, ed;
    do_reset();
    req = 4'b0001;
    set_cnt(0, 5);
    for (int c = 1; c <= 8; c++) begin
      step();
      eg = (c <= 5) ? 4'b0001 : 4'b0000;
      ed = (c == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if ({grant, done, busy} !== {eg, ed, |eg}) begin
        errors++;
        $display("FAIL single c=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", c, grant, done, busy, eg, ed, |eg);
      end
      if (c == 1) begin
        checks++;
        if (active_id !== 2'd0) begin
          errors++;
          $display("FAIL single_id got %0d exp 0", active_id);
        end
      end
      if (c == 6) req = '0;
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg, ed;
    int slot, phase;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_cnt(i, 2);
    for (int c = 1; c <= 16; c++) begin
      step();
      slot  = (c - 1) / 3;
      phase = (c - 1) % 3;
      eg = '0;
      ed = '0;
      if (c <= 15) begin
        if (phase < 2) eg = 4'(1 << (slot % 4));
        else           ed = 4'(1 << (slot % 4));
      end
      checks++;
      if ({grant, done, busy} !== {eg, ed, |eg}) begin
        errors++;
        $display("FAIL rr c=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", c, grant, done, busy, eg, ed, |eg);
      end
      if (c <= 15 && phase == 0) begin
        checks++;
        if (active_id !== 2'(slot % 4)) begin
          errors++;
          $display("FAIL rr_id c=%0d got %0d exp %0d", c, active_id, slot % 4);
        end
      end
      if (c == 15) req = '0;
    end
  endtask

  task automatic test_zero_count();
    logic [N-1:0] eg, ed;
    do_reset();
    req = 4'b0010;
    set_cnt(1, 0);
    for (int c = 1; c <= 3; c++) begin
      step();
      eg = (c == 1) ? 4'b0010 : 4'b0000;
      ed = (c == 2) ? 4'b0010 : 4'b0000;
      checks++;
      if ({grant, done, busy} !== {eg, ed, |eg}) begin
        errors++;
        $display("FAIL zero_cnt c=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", c, grant, done, busy, eg, ed, |eg);
      end
      if (c == 1) begin
        checks++;
        if (active_id !== 2'd1) begin
          errors++;
          $display("FAIL zero_cnt_id got %0d exp 1", active_id);
        end
      end
      if (c == 2) req = '0;
    end
  endtask

  task automatic test_abort();
    logic [N-1:0] eg, ed;
    do_reset();
    req = 4'b0100;
    set_cnt(2, 10);
    for (int c = 1; c <= 7; c++) begin
      step();
      eg = (c <= 3) ? 4'b0100 : (c == 5) ? 4'b0001 : 4'b0000;
      ed = (c == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if ({grant, done, busy} !== {eg, ed, |eg}) begin
        errors++;
        $display("FAIL abort c=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", c, grant, done, busy, eg, ed, |eg);
      end
      if (c == 3) begin
        req = 4'b0001;
        set_cnt(0, 1);
      end
      if (c == 6) req = '0;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] eg, ed;
    do_reset();
    req = 4'b0001;
    set_cnt(0, 8);
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if ({grant, busy} !== {4'b0001, 1'b1}) begin
        errors++;
        $display("FAIL midrst_run c=%0d got g=%b b=%b exp g=0001 b=1", c, grant, busy);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if ({grant, done, busy, active_id} !== 11'd0) begin
      errors++;
      $display("FAIL midrst_clear got g=%b d=%b b=%b id=%0d exp all 0", grant, done, busy, active_id);
    end
    reset = 1'b0;
    req = 4'b0011;
    set_cnt(0, 1);
    set_cnt(1, 1);
    for (int c = 6; c <= 8; c++) begin
      step();
      eg = (c == 6) ? 4'b0001 : 4'b0000;
      ed = (c == 7) ? 4'b0001 : 4'b0000;
      checks++;
      if ({grant, done, busy} !== {eg, ed, |eg}) begin
        errors++;
        $display("FAIL midrst_rr c=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", c, grant, done, busy, eg, ed, |eg);
      end
      if (c == 7) req = '0;
    end
  endtask

  task automatic test_count_latched();
    logic [N-1:0] eg, ed;
    do_reset();
    req = 4'b1000;
    set_cnt(3, 4);
    for (int c = 1; c <= 6; c++) begin
      step();
      eg = (c <= 4) ? 4'b1000 : 4'b0000;
      ed = (c == 5) ? 4'b1000 : 4'b0000;
      checks++;
      if ({grant, done, busy} !== {eg, ed, |eg}) begin
        errors++;
        $display("FAIL latch c=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", c, grant, done, busy, eg, ed, |eg);
      end
      if (c == 1) set_cnt(3, 100);
      if (c == 5) req = '0;
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_count = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_count();
    test_abort();
    test_reset_mid_run();
    test_count_latched();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
